// File: rtl/sym_mod_sched_pkg.sv
// Shared encodings, per-standard subcarrier counts and the scheduler state enum.
package sym_mod_sched_pkg;

    localparam logic [1:0] MOD_Q64   = 2'b11;
    localparam logic [1:0] MOD_Q16   = 2'b10;
    localparam logic [1:0] MOD_QPSK  = 2'b00;
    localparam logic [1:0] MOD_BPSK  = 2'b01;

    localparam logic [1:0] STD_WIFI  = 2'b00;
    localparam logic [1:0] STD_WIMAX = 2'b01;

    localparam int NDATA_WIFI  = 48;
    localparam int NDATA_WIMAX = 192;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_SWITCH = 3'd2,
        S_PAY    = 3'd3,
        S_FIN    = 3'd4
    } state_t;

endpackage

// File: rtl/sym_cnt_unit.sv
// Subcarrier / OFDM-symbol counter pair. sym_last flags the transfer that
// completes the current symbol; sym_end is its registered one-cycle pulse.
module sym_cnt_unit #(
    parameter int SYMW = 8,
    parameter int SCW  = 8
) (
    input  logic            CLK_I,
    input  logic            RST_I,
    input  logic            clr,
    input  logic            sym_clr,
    input  logic            adv,
    input  logic [SCW-1:0]  ndata_m1,
    output logic [SYMW-1:0] sym_cnt,
    output logic            sym_last,
    output logic            sym_end
);

    logic [SCW-1:0] sc_cnt;

    assign sym_last = adv & (sc_cnt == ndata_m1);

    // Count accepted transfers, wrap per symbol; clr (start/abort) has priority.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            sc_cnt  <= '0;
            sym_cnt <= '0;
            sym_end <= 1'b0;
        end else if (clr) begin
            sc_cnt  <= '0;
            sym_cnt <= '0;
            sym_end <= 1'b0;
        end else begin
            sym_end <= sym_last;
            if (adv)
                sc_cnt <= sym_last ? '0 : sc_cnt + SCW'(1);
            if (sym_clr)
                sym_cnt <= '0;
            else if (sym_last)
                sym_cnt <= sym_cnt + SYMW'(1);
        end
    end

endmodule

// File: rtl/sym_mod_sched.sv
// Frame scheduler in front of the symbol modulator: gates the word stream,
// counts subcarriers/symbols and sequences MOD_O with an idle gap before change.
//
// state  | meaning
// IDLE   | waiting for START, gate closed
// HDR    | header symbols, BPSK, gate open
// SWITCH | GAP closed cycles, MOD_O loads payload modulation on the last one
// PAY    | payload symbols, gate open
// FIN    | GAP closed cycles to drain the modulator, then DONE
module sym_mod_sched
    import sym_mod_sched_pkg::*;
#(
    parameter int GAP  = 2,
    parameter int SYMW = 8,
    parameter int SCW  = 8
) (
    input  logic            CLK_I,
    input  logic            RST_I,
    input  logic            START,
    input  logic [1:0]      STD,
    input  logic [1:0]      PAY_MOD,
    input  logic [SYMW-1:0] HDR_SYMS,
    input  logic [SYMW-1:0] PAY_SYMS,
    input  logic [5:0]      DAT_I,
    input  logic            CYC_I,
    input  logic            STB_I,
    input  logic            WE_I,
    output logic            ACK_O,
    output logic [5:0]      DAT_O,
    output logic            CYC_O,
    output logic            STB_O,
    output logic            WE_O,
    input  logic            ACK_I,
    output logic [1:0]      MOD_O,
    output logic [1:0]      STD_O,
    output logic            BUSY,
    output logic            SYM_END,
    output logic            DONE,
    output logic            ERR
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    state_t          state, state_nx;
    logic [1:0]      std_q, pay_mod_q, mod_q;
    logic [SYMW-1:0] hdr_q, pay_q, sym_cnt;
    logic [SCW-1:0]  ndata_m1;
    logic [GW-1:0]   gap_cnt;
    logic            busy_q, done_q, err_q, cyc_q;
    logic            gate, xfer, sym_last, sym_end;
    logic            start_ok, start_bad, abort, gap_last, sw_exit, fin_exit;

    assign gate     = (state == S_HDR) || (state == S_PAY);
    assign xfer     = STB_I & WE_I & ACK_I & gate;
    assign gap_last = (gap_cnt == GW'(GAP - 1));

    assign STB_O   = STB_I & gate;
    assign WE_O    = WE_I & gate;
    assign ACK_O   = ACK_I & gate;
    assign DAT_O   = DAT_I;
    assign CYC_O   = cyc_q & busy_q;
    assign MOD_O   = mod_q;
    assign STD_O   = std_q;
    assign BUSY    = busy_q;
    assign SYM_END = sym_end;
    assign DONE    = done_q;
    assign ERR     = err_q;

    sym_cnt_unit #(.SYMW(SYMW), .SCW(SCW)) u_cnt (
        .CLK_I    (CLK_I),
        .RST_I    (RST_I),
        .clr      (start_ok | abort),
        .sym_clr  (sw_exit),
        .adv      (xfer),
        .ndata_m1 (ndata_m1),
        .sym_cnt  (sym_cnt),
        .sym_last (sym_last),
        .sym_end  (sym_end)
    );

    // State register.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state and event decode; a dropped CYC_I beats any same-cycle completion.
    always_comb begin
        state_nx  = state;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        abort     = 1'b0;
        sw_exit   = 1'b0;
        fin_exit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) begin
                    if (STD[1]) begin
                        start_bad = 1'b1;
                    end else begin
                        start_ok = 1'b1;
                        if (HDR_SYMS != '0)      state_nx = S_HDR;
                        else if (PAY_SYMS != '0) state_nx = S_PAY;
                        else                     state_nx = S_FIN;
                    end
                end
            end
            S_HDR: begin
                if (!CYC_I) begin
                    abort    = 1'b1;
                    state_nx = S_IDLE;
                end else if (sym_last && (sym_cnt == hdr_q - SYMW'(1))) begin
                    state_nx = (pay_q != '0) ? S_SWITCH : S_FIN;
                end
            end
            S_SWITCH: begin
                if (!CYC_I) begin
                    abort    = 1'b1;
                    state_nx = S_IDLE;
                end else if (gap_last) begin
                    sw_exit  = 1'b1;
                    state_nx = S_PAY;
                end
            end
            S_PAY: begin
                if (!CYC_I) begin
                    abort    = 1'b1;
                    state_nx = S_IDLE;
                end else if (sym_last && (sym_cnt == pay_q - SYMW'(1))) begin
                    state_nx = S_FIN;
                end
            end
            S_FIN: begin
                if (gap_last) begin
                    fin_exit = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Closed-gate cycle counter for SWITCH and FIN.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I)
            gap_cnt <= '0;
        else if ((state == S_SWITCH || state == S_FIN) && !gap_last && !abort)
            gap_cnt <= gap_cnt + GW'(1);
        else
            gap_cnt <= '0;
    end

    // Frame configuration latch, MOD/STD drive and status pulses.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            std_q     <= STD_WIFI;
            pay_mod_q <= MOD_QPSK;
            mod_q     <= MOD_QPSK;
            hdr_q     <= '0;
            pay_q     <= '0;
            ndata_m1  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cyc_q     <= 1'b0;
        end else begin
            done_q <= fin_exit;
            err_q  <= start_bad | abort;
            cyc_q  <= CYC_I;
            if (start_ok) begin
                std_q     <= STD;
                pay_mod_q <= PAY_MOD;
                hdr_q     <= HDR_SYMS;
                pay_q     <= PAY_SYMS;
                ndata_m1  <= STD[0] ? SCW'(NDATA_WIMAX - 1) : SCW'(NDATA_WIFI - 1);
                busy_q    <= 1'b1;
                if (HDR_SYMS != '0)      mod_q <= MOD_BPSK;
                else if (PAY_SYMS != '0) mod_q <= PAY_MOD;
            end
            if (fin_exit || abort) busy_q <= 1'b0;
            if (sw_exit)           mod_q  <= pay_mod_q;
        end
    end

endmodule
